keyscan_debounce: RTL and testbench



---
 rtl/keyscan_debounce.sv | 202 ++++++++++++++++++++
 tb/tb_keyscan_debounce.sv | 131 +++++++++++++
 2 files changed

// File: rtl/keyscan_debounce.sv
// rtl/keyscan_debounce.sv - synchronised, priority-encoded, debounced keypad scanner (optional auto-repeat via KEYSCAN_AUTOREPEAT_EN)
module keyscan_debounce #(
    parameter int  NKEYS         = 20,
    parameter int  DEBOUNCE      = 2,
    parameter int  REPEAT_DELAY  = 8,
    parameter int  REPEAT_PERIOD = 4,
    localparam int CW            = $clog2(NKEYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] in,
    output logic [CW-1:0]    out,
    output logic             strobe,
    output logic             press,
    output logic             rel
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DEB_C = DW'(DEBOUNCE);
    localparam logic [DW-1:0] ONE_C = DW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [NKEYS-1:0] sync1_q;
    logic [NKEYS-1:0] in_s_q;

    state_t           state_q;
    state_t           state_d;
    logic [DW-1:0]    cnt_q;
    logic [DW-1:0]    cnt_d;
    logic [CW-1:0]    cand_q;
    logic [CW-1:0]    cand_d;
    logic [CW-1:0]    out_q;
    logic [CW-1:0]    out_d;
    logic             strobe_q;
    logic             strobe_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;

    logic             any;
    logic [CW-1:0]    code;
    logic             rpt_fire;

    // Highest pressed line wins; lower lines are shadowed.
    always_comb begin
        code = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (in_s_q[i]) begin
                code = CW'(i);
            end
        end
    end

    assign any = |in_s_q;

`ifdef KEYSCAN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_q;
    logic [RW-1:0] rpt_d;
    logic [RW-1:0] rpt_inc;
    logic [RW-1:0] rpt_target;
    logic          rep_q;
    logic          rep_d;

    assign rpt_inc    = rpt_q + 1'b1;
    assign rpt_target = rep_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);

    // Repeat timer: first interval is the delay, later ones the period; frozen outside HELD.
    always_comb begin
        rpt_d    = rpt_q;
        rep_d    = rep_q;
        rpt_fire = 1'b0;
        if (state_q == SETTLE && state_d == HELD) begin
            rpt_d = '0;
            rep_d = 1'b0;
        end else if (state_q == HELD) begin
            if (rpt_inc == rpt_target) begin
                rpt_d    = '0;
                rep_d    = 1'b1;
                // A release taking effect this cycle swallows the pulse.
                rpt_fire = any;
            end else begin
                rpt_d = rpt_inc;
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            rpt_q <= rpt_d;
            rep_q <= rep_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            in_s_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync1_q  <= in;
            in_s_q   <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
        end
    end

    // Next-state: a candidate code must stay unchanged for DEBOUNCE cycles to be accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    cand_d  = code;
                    cnt_d   = ONE_C;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!any) begin
                    state_d = IDLE;
                end else if (code != cand_q) begin
                    cand_d = code;
                    cnt_d  = ONE_C;
                end else if (cnt_q == DEB_C) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!any) begin
                    cnt_d   = ONE_C;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (any) begin
                    state_d = HELD;
                end else if (cnt_q == DEB_C) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: code and strobe change only on accepted transitions; pulses last one cycle.
    always_comb begin
        out_d    = out_q;
        strobe_d = strobe_q;
        press_d  = rpt_fire;
        rel_d    = 1'b0;
        if (state_q == SETTLE && state_d == HELD) begin
            out_d    = cand_q;
            strobe_d = 1'b1;
            press_d  = 1'b1;
        end
        if (state_q == RELEASE && state_d == IDLE) begin
            strobe_d = 1'b0;
            rel_d    = 1'b1;
        end
    end

    assign out    = out_q;
    assign strobe = strobe_q;
    assign press  = press_q;
    assign rel    = rel_q;

endmodule

// File: tb/tb_keyscan_debounce.sv
// tb/tb_keyscan_debounce.sv - directed self-checking bench for keyscan_debounce
module tb_keyscan_debounce;

    localparam int NKEYS = 20;
    localparam int CW    = 5;
`ifdef KEYSCAN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NKEYS-1:0] keys;
    logic [CW-1:0]    out_w;
    logic             strobe_w;
    logic             press_w;
    logic             rel_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keyscan_debounce dut (
        .clk    (clk),
        .rst    (rst),
        .in     (keys),
        .out    (out_w),
        .strobe (strobe_w),
        .press  (press_w),
        .rel    (rel_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input int eo, input bit es, input bit ep, input bit er);
        chk({tag, "_out"},    k, 32'(out_w),    32'(eo));
        chk({tag, "_strobe"}, k, 32'(strobe_w), 32'(es));
        chk({tag, "_press"},  k, 32'(press_w),  32'(ep));
        chk({tag, "_rel"},    k, 32'(rel_w),    32'(er));
    endtask

    // Auto-repeat pulse expected at edge k given first repeat edge and last edge seen as held.
    function automatic bit rep(input int k, input int first, input int last);
        return AR && (k >= first) && (k <= last) && (((k - first) % 4) == 0);
    endfunction

    initial begin
        rst  = 1'b1;
        keys = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("reset", k, 0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk_all("post_reset", k, (k >= 4) ? 19 : 0, k >= 4, k == 4, 1'b0);
        end
        keys = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk_all("post_reset_rel", k, 19, k < 4, 1'b0, k == 4);
        end

        keys = 20'(1) << 13;
        for (int k = 0; k < 26; k++) begin
            if (k == 20) keys = '0;
            step();
            chk_all("single", k, (k >= 4) ? 13 : 19, (k >= 4) && (k < 24),
                    (k == 4) || rep(k, 12, 21), k == 24);
        end

        keys = 20'(1) << 5;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) keys = '0;
            step();
            chk_all("glitch", k, 13, 1'b0, 1'b0, 1'b0);
        end

        keys = (20'(1) << 3) | (20'(1) << 17);
        for (int k = 0; k < 23; k++) begin
            if (k == 5)  keys = keys | (20'(1) << 19);
            if (k == 11) keys = '0;
            if (k == 12) keys = (20'(1) << 3) | (20'(1) << 17) | (20'(1) << 19);
            if (k == 17) keys = '0;
            step();
            chk_all("prio_bounce", k, (k >= 4) ? 17 : 13, (k >= 4) && (k < 21),
                    (k == 4) || (AR && (k == 12 || k == 17)), k == 21);
        end

        keys = 20'(1) << 2;
        for (int k = 0; k < 36; k++) begin
            if (k == 30) keys = '0;
            step();
            chk_all("repeat", k, (k >= 4) ? 2 : 17, (k >= 4) && (k < 34),
                    (k == 4) || rep(k, 12, 31), k == 34);
        end

        keys = 20'(1) << 7;
        for (int k = 0; k < 6; k++) begin
            step();
        end
        chk_all("midrst_pre", 0, 7, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk_all("midrst", 0, 0, 1'b0, 1'b0, 1'b0);
        rst  = 1'b0;
        keys = '0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk_all("midrst_after", k, 0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
